// File: rtl/a78_pkg.sv
// Shared types and constants for the A78 cart loader and the mapper that consumes its flag word.
package a78_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIG,
    ST_HDR,
    ST_REPLAY,
    ST_BODY,
    ST_DONE
  } state_t;

  // "ATARI7800", found at file bytes 1..9
  localparam logic [7:0] SIG_STR [0:8] = '{8'h41, 8'h54, 8'h41, 8'h52, 8'h49,
                                           8'h37, 8'h38, 8'h30, 8'h30};

  localparam int SIZE_OFS    = 49;
  localparam int TYPE_HI_OFS = 53;
  localparam int TYPE_LO_OFS = 54;

  localparam int FLAG_ACTIVISION = 8;
  localparam int FLAG_ABSOLUTE   = 9;

endpackage

// File: rtl/a78_replay_buf.sv
// Holds the first SIG_LEN file bytes and replays them to ROM when no header is found,
// followed by at most one byte caught in a skid register while the source was stalled.
module a78_replay_buf #(
  parameter int SIG_LEN = 10,
  parameter int IO_AW   = 25,
  localparam int CW     = $clog2(SIG_LEN + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [CW-1:0]           wr_idx,
  input  logic [7:0]              wr_data,
  output logic [SIG_LEN-1:0][7:0] sbuf_o,
  input  logic                    start,
  input  logic [CW-1:0]           len,
  input  logic                    cap_en,
  input  logic [IO_AW-1:0]        cap_addr,
  input  logic [7:0]              cap_data,
  output logic                    emit,
  output logic [IO_AW-1:0]        emit_addr,
  output logic [7:0]              emit_data,
  output logic                    last
);

  logic [SIG_LEN-1:0][7:0] sbuf_q, sbuf_d;
  logic [CW-1:0]           ptr_q, ptr_d, len_q, len_d;
  logic                    busy_q, busy_d, sk_ph_q, sk_ph_d, skv_q, skv_d;
  logic [IO_AW-1:0]        ska_q, ska_d;
  logic [7:0]              skd_q, skd_d;

  assign sbuf_o = sbuf_q;

  always_comb begin
    sbuf_d    = sbuf_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    busy_d    = busy_q;
    sk_ph_d   = sk_ph_q;
    skv_d     = skv_q;
    ska_d     = ska_q;
    skd_d     = skd_q;
    emit      = 1'b0;
    emit_addr = '0;
    emit_data = '0;
    last      = 1'b0;
    if (wr_en) sbuf_d[wr_idx] = wr_data;
    if (cap_en && busy_q && !skv_q) begin
      skv_d = 1'b1;
      ska_d = cap_addr;
      skd_d = cap_data;
    end
    if (start) begin
      busy_d  = 1'b1;
      ptr_d   = '0;
      len_d   = len;
      sk_ph_d = 1'b0;
      skv_d   = 1'b0;
    end else if (busy_q && !sk_ph_q) begin
      emit      = 1'b1;
      emit_addr = IO_AW'(ptr_q);
      emit_data = sbuf_q[ptr_q];
      if (ptr_q == len_q - CW'(1)) begin
        // a byte caught on this very cycle still gets its own slot
        if (skv_q || cap_en) sk_ph_d = 1'b1;
        else begin
          busy_d = 1'b0;
          last   = 1'b1;
        end
      end else begin
        ptr_d = ptr_q + CW'(1);
      end
    end else if (busy_q) begin
      emit      = 1'b1;
      emit_addr = ska_q;
      emit_data = skd_q;
      busy_d    = 1'b0;
      sk_ph_d   = 1'b0;
      skv_d     = 1'b0;
      last      = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sbuf_q  <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      sk_ph_q <= 1'b0;
      skv_q   <= 1'b0;
      ska_q   <= '0;
      skd_q   <= '0;
    end else begin
      sbuf_q  <= sbuf_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      sk_ph_q <= sk_ph_d;
      skv_q   <= skv_d;
      ska_q   <= ska_d;
      skd_q   <= skd_d;
    end
  end

endmodule

// File: rtl/a78_loader.sv
// A78 cart loader: strips the 128-byte header from the ioctl stream, writes the body to ROM
// and publishes cart_size / cart_flags for the mapper.
//   state  | meaning
//   IDLE   | waiting for a download rising edge
//   SIG    | buffering bytes 0..9 until the signature can be judged
//   HDR    | header found; latching size/type, ROM writes suppressed
//   REPLAY | no header; stall source and replay buffered bytes to ROM
//   BODY   | streaming body bytes to ROM
//   DONE   | one cycle: publish results, pulse load_done
module a78_loader
  import a78_pkg::*;
#(
  parameter int HDR_LEN = 128,
  parameter int SIG_LEN = 10,
  parameter int ROM_AW  = 18,
  parameter int IO_AW   = 25
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [IO_AW-1:0]  ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_wr,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [9:0]        cart_flags,
  output logic [31:0]       cart_size,
  output logic              header_valid,
  output logic              load_done
);

  localparam int CW = $clog2(SIG_LEN + 1);

  state_t state_q, state_d;
  logic dl_q, end_q, hdr_seen_q, hdr_seen_d, end_seen_q, end_seen_d;
  logic [CW-1:0] sig_cnt_q, sig_cnt_d;
  logic [31:0] cnt_q, cnt_d, hsize_q, hsize_d, cart_size_q, cart_size_d;
  logic [1:0] type_hi_q, type_hi_d;
  logic [7:0] type_lo_q, type_lo_d, rom_data_q, rom_data_d;
  logic rom_wr_q, rom_wr_d, header_valid_q, header_valid_d, load_done_q, load_done_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [9:0] cart_flags_q, cart_flags_d;

  logic accept, rise, sig_ok, rb_wr, rb_start, rb_emit, rb_last, cap_en, src_v;
  logic [CW-1:0] rb_len;
  logic [SIG_LEN-1:0][7:0] sbuf;
  logic [IO_AW-1:0] rb_addr, src_a, body_off;
  logic [7:0] rb_data, src_dat;

  // a write on the cycle download falls is still honoured; the end acts a cycle later
  assign accept   = ioctl_wr && (ioctl_download || dl_q);
  assign rise     = ioctl_download && !dl_q;
  assign cap_en   = (state_q == ST_REPLAY) && accept;
  assign body_off = ioctl_addr - (hdr_seen_q ? IO_AW'(HDR_LEN) : IO_AW'(0));

  always_comb begin
    sig_ok = (ioctl_dout == SIG_STR[SIG_LEN-2]);
    for (int i = 1; i < SIG_LEN - 1; i++)
      if (sbuf[i] != SIG_STR[i-1]) sig_ok = 1'b0;
  end

  a78_replay_buf #(.SIG_LEN(SIG_LEN), .IO_AW(IO_AW)) u_replay (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (rb_wr),
    .wr_idx    (ioctl_addr[CW-1:0]),
    .wr_data   (ioctl_dout),
    .sbuf_o    (sbuf),
    .start     (rb_start),
    .len       (rb_len),
    .cap_en    (cap_en),
    .cap_addr  (ioctl_addr),
    .cap_data  (ioctl_dout),
    .emit      (rb_emit),
    .emit_addr (rb_addr),
    .emit_data (rb_data),
    .last      (rb_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rise) state_d = ST_SIG;
      ST_SIG: begin
        if (accept && ioctl_addr == IO_AW'(SIG_LEN - 1)) state_d = sig_ok ? ST_HDR : ST_REPLAY;
        else if (end_q) state_d = (sig_cnt_q == '0) ? ST_DONE : ST_REPLAY;
      end
      ST_HDR: begin
        if (accept && ioctl_addr == IO_AW'(HDR_LEN - 1)) state_d = ST_BODY;
        else if (end_q) state_d = ST_DONE;
      end
      ST_REPLAY: if (rb_last) state_d = (end_seen_q || end_q) ? ST_DONE : ST_BODY;
      ST_BODY:   if (end_q) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait   = (state_q == ST_REPLAY);
    rom_wr       = rom_wr_q;
    rom_addr     = rom_addr_q;
    rom_data     = rom_data_q;
    cart_flags   = cart_flags_q;
    cart_size    = cart_size_q;
    header_valid = header_valid_q;
    load_done    = load_done_q;
  end

  always_comb begin
    hdr_seen_d     = hdr_seen_q;
    end_seen_d     = end_seen_q;
    sig_cnt_d      = sig_cnt_q;
    cnt_d          = cnt_q;
    hsize_d        = hsize_q;
    type_hi_d      = type_hi_q;
    type_lo_d      = type_lo_q;
    rom_wr_d       = 1'b0;
    rom_addr_d     = rom_addr_q;
    rom_data_d     = rom_data_q;
    header_valid_d = header_valid_q;
    cart_size_d    = cart_size_q;
    cart_flags_d   = cart_flags_q;
    load_done_d    = 1'b0;
    rb_wr          = 1'b0;
    rb_start       = (state_q == ST_SIG) && (state_d == ST_REPLAY);
    rb_len         = accept ? CW'(SIG_LEN) : sig_cnt_q;
    src_v          = 1'b0;
    src_a          = ioctl_addr;
    src_dat        = ioctl_dout;
    case (state_q)
      ST_IDLE: if (rise) begin
        cnt_d      = '0;
        hsize_d    = '0;
        type_hi_d  = '0;
        type_lo_d  = '0;
        hdr_seen_d = 1'b0;
        end_seen_d = 1'b0;
        sig_cnt_d  = '0;
      end
      ST_SIG: begin
        if (accept && ioctl_addr < IO_AW'(SIG_LEN)) begin
          rb_wr     = 1'b1;
          sig_cnt_d = ioctl_addr[CW-1:0] + CW'(1);
        end
        if (end_q) end_seen_d = 1'b1;
      end
      ST_HDR: if (accept) begin
        if (ioctl_addr == IO_AW'(SIZE_OFS))     hsize_d[31:24] = ioctl_dout;
        if (ioctl_addr == IO_AW'(SIZE_OFS + 1)) hsize_d[23:16] = ioctl_dout;
        if (ioctl_addr == IO_AW'(SIZE_OFS + 2)) hsize_d[15:8]  = ioctl_dout;
        if (ioctl_addr == IO_AW'(SIZE_OFS + 3)) hsize_d[7:0]   = ioctl_dout;
        if (ioctl_addr == IO_AW'(TYPE_HI_OFS))  type_hi_d      = ioctl_dout[1:0];
        if (ioctl_addr == IO_AW'(TYPE_LO_OFS))  type_lo_d      = ioctl_dout;
      end
      ST_REPLAY: begin
        src_v   = rb_emit;
        src_a   = rb_addr;
        src_dat = rb_data;
        if (end_q) end_seen_d = 1'b1;
      end
      ST_BODY: if (accept) begin
        src_v = 1'b1;
        src_a = body_off;
      end
      default: ;
    endcase
    // bytes past the ROM window are counted but not written
    if (src_v) begin
      cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
      rom_wr_d   = (src_a[IO_AW-1:ROM_AW] == '0);
      rom_addr_d = src_a[ROM_AW-1:0];
      rom_data_d = src_dat;
    end
    if (state_q == ST_HDR && state_d == ST_BODY) hdr_seen_d = 1'b1;
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      load_done_d    = 1'b1;
      header_valid_d = hdr_seen_d;
      cart_size_d    = (hdr_seen_d && hsize_q != '0) ? hsize_q : cnt_d;
      cart_flags_d   = '0;
      if (hdr_seen_d) begin
        cart_flags_d[7:0]             = type_lo_q;
        cart_flags_d[FLAG_ACTIVISION] = type_hi_q[1];
        cart_flags_d[FLAG_ABSOLUTE]   = type_hi_q[0];
      end
    end
  end

  // dl_q resets high so a download already in progress at reset never looks like a new one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dl_q           <= 1'b1;
      end_q          <= 1'b0;
      hdr_seen_q     <= 1'b0;
      end_seen_q     <= 1'b0;
      sig_cnt_q      <= '0;
      cnt_q          <= '0;
      hsize_q        <= '0;
      type_hi_q      <= '0;
      type_lo_q      <= '0;
      rom_wr_q       <= 1'b0;
      rom_addr_q     <= '0;
      rom_data_q     <= '0;
      header_valid_q <= 1'b0;
      cart_size_q    <= '0;
      cart_flags_q   <= '0;
      load_done_q    <= 1'b0;
    end else begin
      dl_q           <= ioctl_download;
      end_q          <= dl_q && !ioctl_download;
      hdr_seen_q     <= hdr_seen_d;
      end_seen_q     <= end_seen_d;
      sig_cnt_q      <= sig_cnt_d;
      cnt_q          <= cnt_d;
      hsize_q        <= hsize_d;
      type_hi_q      <= type_hi_d;
      type_lo_q      <= type_lo_d;
      rom_wr_q       <= rom_wr_d;
      rom_addr_q     <= rom_addr_d;
      rom_data_q     <= rom_data_d;
      header_valid_q <= header_valid_d;
      cart_size_q    <= cart_size_d;
      cart_flags_q   <= cart_flags_d;
      load_done_q    <= load_done_d;
    end
  end

endmodule

// File: tb/tb_a78_loader.sv
// Directed bench for a78_loader: header, headerless, type flags, short file, skid and mid-load reset.
module tb_a78_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait, rom_wr, header_valid, load_done;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic [9:0]  cart_flags;
  logic [31:0] cart_size;

  always #5 clock = ~clock;

  a78_loader dut (
    .clock          (clock),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_wr         (rom_wr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .cart_flags     (cart_flags),
    .cart_size      (cart_size),
    .header_valid   (header_valid),
    .load_done      (load_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit          g_hdr;
  logic [31:0] g_size;
  logic [15:0] g_type;
  int          g_off;

  logic        mon_clr;
  int          wr_cnt, bad, done_cnt, nxt, run, max_run;
  logic [17:0] first_a;
  logic [7:0]  first_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // file content: header fields at their offsets, otherwise an address-derived pattern
  function automatic logic [7:0] file_byte(input int a);
    int t;
    if (g_hdr) begin
      case (a)
        0:  return 8'h01;
        1:  return 8'h41;
        2:  return 8'h54;
        3:  return 8'h41;
        4:  return 8'h52;
        5:  return 8'h49;
        6:  return 8'h37;
        7:  return 8'h38;
        8:  return 8'h30;
        9:  return 8'h30;
        49: return g_size[31:24];
        50: return g_size[23:16];
        51: return g_size[15:8];
        52: return g_size[7:0];
        53: return g_type[15:8];
        54: return g_type[7:0];
        default: ;
      endcase
    end else if (a == 1) begin
      return 8'h58;
    end
    t = a ^ (a >> 8);
    return t[7:0] ^ 8'h5A;
  endfunction

  always @(negedge clock) begin
    if (mon_clr) begin
      wr_cnt <= 0; bad <= 0; done_cnt <= 0; nxt <= 0; run <= 0; max_run <= 0;
      first_a <= '1; first_d <= '0;
    end else begin
      if (rom_wr) begin
        if (wr_cnt == 0) begin
          first_a <= rom_addr;
          first_d <= rom_data;
        end
        if (int'(rom_addr) != nxt || rom_data != file_byte(int'(rom_addr) + g_off)) bad <= bad + 1;
        nxt    <= nxt + 1;
        wr_cnt <= wr_cnt + 1;
      end
      if (load_done) done_cnt <= done_cnt + 1;
      run <= ioctl_wait ? run + 1 : 0;
      if (ioctl_wait && run + 1 > max_run) max_run <= run + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clock);
    #1 mon_clr = 1'b0;
  endtask

  // streams n file bytes, honouring ioctl_wait except for a forced write at addr 10 when skid=1
  task automatic send_file(input int n, input bit skid);
    int a = 0;
    int guard = 0;
    while (a < n && guard < n + 1000) begin
      tick();
      guard++;
      if (!ioctl_wait || (skid && a == 10)) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = file_byte(a);
        a++;
      end else begin
        ioctl_wr = 1'b0;
      end
    end
    tick();
    ioctl_wr = 1'b0;
    if (a < n) check("send_timeout", 32'(a), 32'(n));
  endtask

  task automatic run_load(input bit hdr, input logic [31:0] sz, input logic [15:0] ty,
                          input int n, input bit skid);
    bit got = 1'b0;
    g_hdr = hdr; g_size = sz; g_type = ty; g_off = hdr ? 128 : 0;
    mon_clear();
    tick();
    ioctl_download = 1'b1;
    tick();
    tick();
    send_file(n, skid);
    ioctl_download = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (load_done) got = 1'b1;
    end
    check("load_done_seen", 32'(got), 1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    mon_clr = 1'b1; g_hdr = 1'b0; g_size = '0; g_type = '0; g_off = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_rom_wr", rom_wr, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_hv", header_valid, 0);
    check("rst_size", cart_size, 0);
    check("rst_flags", cart_flags, 0);
    check("rst_done", load_done, 0);

    // valid header, size 0x20000, type 0x0002 (short body keeps runtime small)
    run_load(1'b1, 32'h0002_0000, 16'h0002, 128 + 256, 1'b0);
    check("hdr_first_addr", first_a, 0);
    check("hdr_first_data", first_d, 8'hDA);
    check("hdr_wr_cnt", wr_cnt, 256);
    check("hdr_bad", bad, 0);
    check("hdr_hv", header_valid, 1);
    check("hdr_size", cart_size, 32'h0002_0000);
    check("hdr_flags", cart_flags, 10'h002);
    check("hdr_done_once", done_cnt, 1);

    run_load(1'b1, 32'h0000_8000, 16'h0200, 128 + 16, 1'b0);
    check("actv_flags", cart_flags, 10'h100);
    check("actv_size", cart_size, 32'h8000);

    run_load(1'b1, 32'h0000_8000, 16'h0100, 128 + 16, 1'b0);
    check("abs_flags", cart_flags, 10'h200);
    check("abs_hv", header_valid, 1);

    // reset in the middle of a body, download kept high
    g_hdr = 1'b1; g_size = 32'h8000; g_type = 16'h0000; g_off = 128;
    mon_clear();
    tick();
    ioctl_download = 1'b1;
    tick();
    tick();
    send_file(200, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("rstmid_rom_wr", rom_wr, 0);
    check("rstmid_hv", header_valid, 0);
    check("rstmid_size", cart_size, 0);
    check("rstmid_flags", cart_flags, 0);
    check("rstmid_wait", ioctl_wait, 0);
    tick();
    reset = 1'b0;
    mon_clear();
    for (int i = 0; i < 20; i++) begin
      tick();
      ioctl_wr = 1'b1; ioctl_addr = 25'(200 + i); ioctl_dout = file_byte(200 + i);
    end
    tick();
    ioctl_wr = 1'b0;
    repeat (3) tick();
    ioctl_download = 1'b0;
    repeat (10) tick();
    check("rstmid_ignored_wr", wr_cnt, 0);
    check("rstmid_no_done", done_cnt, 0);

    // 5-byte file after the reset: fresh download must work
    run_load(1'b0, 32'h0, 16'h0, 5, 1'b0);
    check("short_wr_cnt", wr_cnt, 5);
    check("short_bad", bad, 0);
    check("short_first_addr", first_a, 0);
    check("short_size", cart_size, 5);
    check("short_hv", header_valid, 0);

    run_load(1'b0, 32'h0, 16'h0, 32'h8000, 1'b0);
    check("hl_wait_ge10", 32'(max_run >= 10), 1);
    check("hl_first_data", first_d, 8'h5A);
    check("hl_wr_cnt", wr_cnt, 32'h8000);
    check("hl_bad", bad, 0);
    check("hl_size", cart_size, 32'h8000);
    check("hl_flags", cart_flags, 0);
    check("hl_hv", header_valid, 0);

    run_load(1'b1, 32'h0, 16'h0000, 128 + 32'h4000, 1'b0);
    check("hsz0_size", cart_size, 32'h4000);
    check("hsz0_wr_cnt", wr_cnt, 32'h4000);
    check("hsz0_hv", header_valid, 1);

    // mismatch with one write landing in the first REPLAY cycle
    run_load(1'b0, 32'h0, 16'h0, 20, 1'b1);
    check("skid_wr_cnt", wr_cnt, 20);
    check("skid_bad", bad, 0);
    check("skid_size", cart_size, 20);
    check("skid_wait_ge10", 32'(max_run >= 10), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a78_loader.md
Name: a78_loader

Overview:
- Sits directly upstream of the cart mapper, between the HPS ioctl download stream and the cart ROM SDRAM/BRAM write port.
- Detects and strips the 128-byte A78 header.
- Writes ROM body bytes to ROM address 0 onward.
- Decodes the header size and type into the cart_size and cart_flags words the mapper consumes.
- Headerless files pass through unmodified. Size is then taken from the byte count and flags are zero.

Parameters:
- HDR_LEN, 128: header length in bytes; body offset when a header is present.
- SIG_LEN, 10: bytes buffered before the header decision (version byte plus "ATARI7800").
- ROM_AW, 18: ROM write address width; matches the mapper rom_address.
- IO_AW, 25: ioctl_addr width.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ioctl_download, in, 1: high for the duration of a cart file download.
- ioctl_wr, in, 1: one-cycle strobe; byte valid.
- ioctl_addr, in, IO_AW: byte address in the file, sequential from 0.
- ioctl_dout, in, 8: file byte.
- ioctl_wait, out, 1: stall request to the source.
- rom_wr, out, 1: one-cycle ROM write strobe.
- rom_addr, out, ROM_AW: ROM write address.
- rom_data, out, 8: ROM write data.
- cart_flags, out, 10: mapper flag word.
- cart_size, out, 32: ROM body size in bytes.
- header_valid, out, 1: the last load carried an A78 header.
- load_done, out, 1: one-cycle pulse when outputs update after a load.

Behaviour:
- Reset (async): state IDLE. Every output is 0 except cart_size, which is 0 as well. Buffer and counters are cleared.
- Download start: the rising edge of ioctl_download (registered) takes IDLE→SIG and clears the byte count and the staged size and flags.
- Reset while ioctl_download is high: the block returns to IDLE and ignores bytes until the next rising edge.
- SIG state:
  - Each ioctl_wr stores the byte in buf[ioctl_addr] for addr < SIG_LEN. Nothing is written to ROM.
  - When byte 9 is accepted, bytes 1..9 are compared against ASCII "ATARI7800".
  - Match → HDR. Mismatch → REPLAY.
- HDR state: ROM writes are suppressed. Header fields are latched from addresses:
  - 49..52: size, big-endian, addr 49 = MSB.
  - 53: type_hi.
  - 54: type_lo.
- HDR exit: on the write with ioctl_addr == HDR_LEN-1, the block goes to BODY and sets hdr_seen.
- REPLAY state:
  - ioctl_wait is high for the entire state.
  - Buffered bytes 0..9 are emitted as rom_wr, one per cycle, at rom_addr 0..9.
  - Any single ioctl_wr arriving during REPLAY is captured in a 1-entry skid register and emitted on the cycle after the last replay byte.
  - REPLAY then goes to BODY. ioctl_wait drops on the cycle after REPLAY exits.
- BODY state:
  - Each ioctl_wr produces rom_wr on the next cycle (1-cycle latency).
  - rom_addr = ioctl_addr − (hdr_seen ? HDR_LEN : 0), truncated to ROM_AW.
  - rom_data = byte.
  - The body byte count increments, saturating at 2^32−1.
  - If the untruncated offset ≥ 2^ROM_AW, rom_wr is suppressed but the count still increments.
- Download end: the falling edge of ioctl_download is taken from any active state.
  - If it falls in SIG (file shorter than SIG_LEN), the block enters REPLAY with only the received bytes, then finishes.
  - If it falls in HDR (truncated header), header_valid is 0, cart_size is 0 and cart_flags is 0.
  - Otherwise it goes to DONE, which lasts one cycle.
- DONE state (one cycle): updates outputs and pulses load_done, then goes to IDLE. Outputs hold until the next DONE or reset.
  - header_valid = hdr_seen.
  - cart_size = (hdr_seen and header size ≠ 0) ? header size : body count.
  - cart_flags[7:0] = type_lo[7:0].
  - cart_flags[8] = type_hi[1] (header 0x0200 → Activision).
  - cart_flags[9] = type_hi[0] (header 0x0100 → Absolute).
  - Without a header, cart_flags = 0.
- Writes with ioctl_download low, or in IDLE or DONE, are ignored.
- Simultaneous download fall and ioctl_wr: the write is processed first and the end sequence starts on the next cycle.

Decomposition:
- Package a78_pkg holds:
  - state enum (IDLE, SIG, HDR, REPLAY, BODY, DONE);
  - the "ATARI7800" signature constant array;
  - the header field offsets (SIZE_OFS = 49, TYPE_HI_OFS = 53, TYPE_LO_OFS = 54);
  - the cart_flags bit index constants shared with the mapper.
- One sub-module, a78_replay_buf: SIG_LEN×8 buffer, replay pointer and skid register, with a start/busy/last handshake.

Test Plan:
- Valid header:
  - Stimulus: 128-byte header with size 0x00020000 and type 0x0002, followed by 0x20000 body bytes.
  - Required response: first rom_wr at addr 0 carries file byte 128; header_valid = 1; cart_size = 0x20000; cart_flags = 0x002; load_done pulses once.
- Headerless 32 KB:
  - Stimulus: byte 1 = 'X'.
  - Required response: ioctl_wait is high for ≥10 cycles; rom addr 0..9 hold the original bytes; cart_size = 0x8000; cart_flags = 0; header_valid = 0.
- Activision type:
  - Stimulus: header type 0x0200.
  - Required response: cart_flags = 0x100.
- Absolute type:
  - Stimulus: header type 0x0100.
  - Required response: cart_flags = 0x200.
- Header size 0:
  - Stimulus: header with size field 0 and 0x4000 body bytes.
  - Required response: cart_size = 0x4000.
- Short file and skid:
  - Stimulus 1: 5-byte file.
  - Required response 1: 5 rom_wr at addr 0..4; cart_size = 5.
  - Stimulus 2: a mismatch, with one ioctl_wr arriving in the first REPLAY cycle.
  - Required response 2: that byte is written at its address after byte 9, with none lost.
- Reset mid-BODY:
  - Stimulus: assert reset during BODY, keep ioctl_download high.
  - Required response: all outputs are 0 immediately; further writes are ignored until a new download rising edge.
